// File: rtl/reg_dump_unit_if.sv
// Record stream carried from the register dump engine to its consumer.
// A record moves on a cycle where out_valid and out_ready are both high.
interface reg_dump_unit_if #(
    parameter int DATA_W = 32
) ();
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [5:0]        out_tag;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_tag,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_tag,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/reg_dump_unit.sv
// Debug readout engine: streams a PC header followed by the masked GPRs in
// ascending index order, one record per handshake, through a spare RF read port.
module reg_dump_unit #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic [NUM_REGS-1:0] mask,
    input  logic [DATA_W-1:0]   pc_in,
    output logic [ADDR_W-1:0]   rf_rd_addr,
    input  logic [DATA_W-1:0]   rf_rd_data,
    reg_dump_unit_if.master     out_if,
    output logic                busy,
    output logic                done
);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        SCAN,
        EMIT,
        DONE
    } state_e;

    localparam logic [5:0] PC_TAG = 6'h20;

    state_e              state_q;
    logic [NUM_REGS-1:0] mask_rem_q;
    logic [ADDR_W-1:0]   rf_rd_addr_q;
    logic                out_valid_q;
    logic [DATA_W-1:0]   out_data_q;
    logic [5:0]          out_tag_q;
    logic                out_last_q;
    logic                busy_q;
    logic                done_q;

    logic [ADDR_W-1:0]   low_idx;
    logic [NUM_REGS-1:0] mask_rem_d;
    logic                handshake;

    function automatic logic [ADDR_W-1:0] lowest_set(input logic [NUM_REGS-1:0] m);
        lowest_set = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (m[i]) lowest_set = ADDR_W'(i);
        end
    endfunction

    // rf_rd_addr_q already holds the index being read while in SCAN.
    always_comb begin
        low_idx    = lowest_set(mask_rem_q);
        mask_rem_d = mask_rem_q & ~(NUM_REGS'(1) << rf_rd_addr_q);
        handshake  = out_valid_q && out_if.out_ready;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; reset is asynchronous and clears all state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            mask_rem_q   <= '0;
            rf_rd_addr_q <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_tag_q    <= '0;
            out_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mask_rem_q  <= mask;
                        out_data_q  <= pc_in;
                        out_tag_q   <= PC_TAG;
                        out_last_q  <= (mask == '0);
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= HEADER;
                    end
                end

                HEADER, EMIT: begin
                    if (handshake) begin
                        out_valid_q <= 1'b0;
                        if (out_last_q) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            rf_rd_addr_q <= low_idx;
                            state_q      <= SCAN;
                        end
                    end
                end

                SCAN: begin
                    out_data_q   <= rf_rd_data;
                    out_tag_q    <= 6'(rf_rd_addr_q);
                    out_last_q   <= (mask_rem_d == '0);
                    mask_rem_q   <= mask_rem_d;
                    rf_rd_addr_q <= '0;
                    out_valid_q  <= 1'b1;
                    state_q      <= EMIT;
                end

                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign rf_rd_addr       = rf_rd_addr_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign out_if.out_valid = out_valid_q;
    assign out_if.out_data  = out_data_q;
    assign out_if.out_tag   = out_tag_q;
    assign out_if.out_last  = out_last_q;

endmodule

// File: tb/tb_reg_dump_unit.sv
// Self-checking bench for reg_dump_unit: directed scenarios plus randomized
// dumps compared against a record-list model of the expected stream.
module tb_reg_dump_unit;

    typedef struct {
        logic [31:0] data;
        logic [5:0]  tag;
        logic        last;
    } rec_t;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [31:0] mask;
    logic [31:0] pc_in;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
    logic        busy;
    logic        done;
    logic        ready;

    logic [31:0] regs [32];
    rec_t        exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    reg_dump_unit_if #(.DATA_W(32)) dump_if ();

    reg_dump_unit #(
        .NUM_REGS(32),
        .DATA_W  (32),
        .ADDR_W  (5)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .mask      (mask),
        .pc_in     (pc_in),
        .rf_rd_addr(rf_rd_addr),
        .rf_rd_data(rf_rd_data),
        .out_if    (dump_if.master),
        .busy      (busy),
        .done      (done)
    );

    assign dump_if.out_ready = ready;
    assign rf_rd_data = (rf_rd_addr == 5'd0) ? 32'h0 : regs[rf_rd_addr];

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected stream: PC header, then each set mask bit low to high.
    task automatic build_expected(input logic [31:0] m, input logic [31:0] pc);
        int n;
        int cnt;
        rec_t r;
        exp_q.delete();
        n = $countones(m);
        r.data = pc; r.tag = 6'h20; r.last = (n == 0);
        exp_q.push_back(r);
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            if (m[i]) begin
                cnt++;
                r.data = (i == 0) ? 32'h0 : regs[i];
                r.tag  = 6'(i);
                r.last = (cnt == n);
                exp_q.push_back(r);
            end
        end
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_valid"}, dump_if.out_valid, 0);
        check({pfx, "_data"},  dump_if.out_data, 0);
        check({pfx, "_tag"},   dump_if.out_tag, 0);
        check({pfx, "_last"},  dump_if.out_last, 0);
        check({pfx, "_busy"},  busy, 0);
        check({pfx, "_done"},  done, 0);
        check({pfx, "_addr"},  rf_rd_addr, 0);
    endtask

    // Called #1 after a rising edge; returns #1 after a rising edge.
    task automatic run_dump(input logic [31:0] m, input logic [31:0] pc, input bit rnd_ready,
                            input int stall_tag, input int stall_n, input bit poke_start);
        int   n;
        int   last_hs;
        int   stall_left;
        bit   finished;
        bit   have_hold;
        rec_t e;
        rec_t hold;
        build_expected(m, pc);
        n = $countones(m);
        start = 1'b1; mask = m; pc_in = pc;
        @(posedge clock); #1;
        start = 1'b0; mask = $urandom; pc_in = $urandom;
        finished = 0; have_hold = 0; last_hs = -10; stall_left = stall_n;
        for (int cyc = 1; cyc <= 400 && !finished; cyc++) begin
            if (dump_if.out_valid && int'(dump_if.out_tag) == stall_tag && stall_left > 0) begin
                ready = 1'b0;
                stall_left--;
            end else begin
                ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            start = poke_start && (cyc == 2 || cyc == 5);
            @(negedge clock);
            if (cyc == 1) check("hdr_latency", dump_if.out_valid, 1);
            if (dump_if.out_valid) begin
                check("no_b2b", (cyc == last_hs + 1), 0);
                check("addr_valid", rf_rd_addr, 0);
                if (have_hold) begin
                    check("hold_data", dump_if.out_data, hold.data);
                    check("hold_tag",  dump_if.out_tag, hold.tag);
                    check("hold_last", dump_if.out_last, hold.last);
                end
                if (ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_rec", dump_if.out_tag, 6'h3f);
                    end else begin
                        e = exp_q.pop_front();
                        check("rec_data", dump_if.out_data, e.data);
                        check("rec_tag",  dump_if.out_tag, e.tag);
                        check("rec_last", dump_if.out_last, e.last);
                    end
                    last_hs   = cyc;
                    have_hold = 0;
                end else begin
                    hold.data = dump_if.out_data;
                    hold.tag  = dump_if.out_tag;
                    hold.last = dump_if.out_last;
                    have_hold = 1;
                end
            end else begin
                if (have_hold) check("valid_drop", dump_if.out_valid, 1);
                if (done) begin
                    check("done_empty", exp_q.size(), 0);
                    check("done_timing", cyc, last_hs + 1);
                    check("done_busy", busy, 0);
                    check("addr_done", rf_rd_addr, 0);
                    if (!rnd_ready && stall_n == 0) check("dump_cycles", cyc, 2 * n + 2);
                    finished = 1;
                end else if (busy) begin
                    if (exp_q.size() > 0) check("scan_addr", rf_rd_addr, exp_q[0].tag);
                    else check("scan_extra", busy, 0);
                end else begin
                    check("busy_gap", busy, 1);
                end
            end
            @(posedge clock); #1;
        end
        if (!finished) check("timeout_done", finished, 1);
        start = 1'b0; ready = 1'b1;
        @(negedge clock);
        check("post_valid", dump_if.out_valid, 0);
        check("post_busy", busy, 0);
        check("post_done", done, 0);
        @(posedge clock); #1;
    endtask

    task automatic reset_mid_emit();
        bit found;
        found = 0;
        build_expected(32'h6, 32'h1234);
        start = 1'b1; mask = 32'h6; pc_in = 32'h1234; ready = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 20 && !found; cyc++) begin
            if (dump_if.out_valid && dump_if.out_tag != 6'h20) begin
                found = 1;
            end else begin
                @(posedge clock); #1;
            end
        end
        check("rst_reached_emit", found, 1);
        ready = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_values("rst_async");
        @(posedge clock); #1;
        check_reset_values("rst_held");
        reset_n = 1'b1;
        ready = 1'b1;
        @(posedge clock); #1;
    endtask

    initial begin
        clock = 1'b0; reset_n = 1'b0; start = 1'b0;
        mask = '0; pc_in = '0; ready = 1'b1;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        #12;
        check_reset_values("por");
        reset_n = 1'b1;
        @(posedge clock); #1;

        regs[16] = 32'h5;
        run_dump(32'h0001_0000, 32'h40, 0, -1, 0, 0);
        run_dump(32'h0, 32'h1C, 0, -1, 0, 0);
        regs[8] = 32'h11; regs[10] = 32'h22; regs[11] = 32'h33;
        run_dump(32'h0000_0D00, 32'h100, 0, -1, 0, 0);
        run_dump(32'h0000_0D00, 32'h104, 0, 10, 3, 0);
        run_dump(32'h0000_0D00, 32'h108, 0, 32, 2, 1);
        run_dump(32'h8000_0001, 32'h10C, 0, -1, 0, 0);

        reset_mid_emit();
        regs[0] = 32'hDEAD_BEEF;
        run_dump(32'h1, 32'h200, 0, -1, 0, 0);

        run_dump(32'hFFFF_FFFF, $urandom, 1, -1, 0, 0);
        for (int it = 0; it < 30; it++) begin
            logic [31:0] m;
            for (int i = 0; i < 32; i++) regs[i] = $urandom;
            m = $urandom;
            if (it % 3 == 0) m = m & $urandom & $urandom;
            run_dump(m, $urandom, 1'($urandom_range(0, 1)), -1, 0, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_dump_unit.md
# reg_dump_unit

Debug readout engine that streams a snapshot of the PC and a selected subset of the 32 MIPS general-purpose registers out of the `Pipeline` top level. It sits beside the register file, drives a spare read port, and emits one record per handshake on a valid/ready output. It is the in-design producer of the register trace that the simulation bench currently collects by peeking into the hierarchy, so the same data becomes available on FPGA pins or a UART bridge.

## Interface
Parameters:
- `NUM_REGS`, 32: register file depth.
- `DATA_W`, 32: register and PC width.
- `ADDR_W`, 5: register address width.

Ports:
- `clock`, in, 1: single clock; all state updates on the rising edge.
- `reset_n`, in, 1: reset, asynchronous and active-low.
- `start`, in, 1: dump request; sampled only in IDLE.
- `mask`, in, NUM_REGS: bit i set means register i is dumped; sampled with `start`.
- `pc_in`, in, DATA_W: current PC; sampled with `start`.
- `rf_rd_addr`, out, ADDR_W: address to the register file's spare combinational read port.
- `rf_rd_data`, in, DATA_W: read data for `rf_rd_addr`, valid in the same cycle.
- `out_valid`, out, 1: a record is presented.
- `out_ready`, in, 1: consumer accepts the record.
- `out_data`, out, DATA_W: record payload.
- `out_tag`, out, 6: 0x20 for the PC header; 0x00–0x1F for a register index.
- `out_last`, out, 1: final record of the dump.
- `busy`, out, 1: a dump is in progress.
- `done`, out, 1: one-cycle pulse after the final handshake.

## Operation
- States: IDLE, HEADER, SCAN, EMIT, DONE.
- IDLE:
  - `start`=1 latches `mask` into `mask_rem` and `pc_in` into the PC snapshot.
  - Loads `out_data` with the PC snapshot, `out_tag` with 0x20, and `out_last` with (`mask`==0).
  - Moves to HEADER.
- HEADER:
  - `out_valid`=1. Stay until `out_valid && out_ready`.
  - On that handshake: go to DONE if `out_last`, else go to SCAN.
- SCAN (always exactly one cycle):
  - `rf_rd_addr` = index i of the lowest set bit of `mask_rem`.
  - At the edge: `out_data` <= `rf_rd_data`, `out_tag` <= i, `out_last` <= (`mask_rem` with bit i cleared == 0), and bit i of `mask_rem` is cleared.
  - Moves to EMIT.
- EMIT:
  - `out_valid`=1. Stay until handshake.
  - On handshake: go to DONE if `out_last`, else go to SCAN.
- DONE: `done`=1 for one cycle, then IDLE.
- `rf_rd_addr` = 0 in every state except SCAN.
- `busy` = 1 in HEADER, SCAN and EMIT.
- `start` outside IDLE is ignored and does not queue.
- Register 0 may be dumped; it reads 0.
- Records are emitted in ascending register index order.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_tag`=0, `out_last`=0, `busy`=0, `done`=0, `rf_rd_addr`=0, `mask_rem`=0, PC snapshot=0, state IDLE.
- `start` at edge k puts the header valid in cycle k+1.
- With `out_ready` held at 1, a dump of N registers takes 2N+1 valid/scan cycles after `start`, then 1 DONE cycle.
- While `out_valid`=1 and `out_ready`=0, `out_data`, `out_tag` and `out_last` hold stable.
- `out_valid` is never deasserted before its handshake.
- `out_valid` is always 0 in SCAN; there are no back-to-back records.
- A register value reflects the register file contents at the SCAN edge. A write landing on that same edge is not seen.
- `reset_n` low at any time, including mid-record, forces all reset values immediately. The partial dump is abandoned, with no `done` and no `out_last`.

## Test plan
- Reset: assert `reset_n`=0 mid-EMIT → outputs go to reset values without waiting for a clock edge. After release, `start` with `mask`=0x1 runs a complete, correct dump.
- Single register: `$s0`=0x5, `pc_in`=0x40, `mask`=0x00010000, `out_ready`=1.
  - Cycle 1: record (0x40, tag 0x20, last 0).
  - Cycle 3: record (0x5, tag 16, last 1).
  - Cycle 4: `done`=1.
- Empty mask: `mask`=0, `pc_in`=0x1C → single record (0x1C, 0x20, last 1), then `done`; `rf_rd_addr` stays 0.
- Ordering: `mask`=0x00000D00, `$t0`=0x11, `$t2`=0x22, `$t3`=0x33 → tags 8, 10, 11 with data 0x11, 0x22, 0x33; `out_last` set only on tag 11.
- Backpressure: `out_ready`=0 for 3 cycles on the tag-10 record → `out_data`, `out_tag` and `out_last` stay constant; the next record follows one cycle after the handshake.
- `start` pulsed during a dump → ignored. No second header appears, and `busy` falls after the single `done`.
